// File: rtl/mdu_ctrl.sv
// Issue/stall controller for the multiply/divide unit beside the E stage.
// Tracks the unit's busy window locally and flags any disagreement with it.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_valid,
  input  logic        e_md_valid,
  input  logic [2:0]  e_mdop,
  input  logic        md_busy,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        stall_d,
  output logic        busy_shadow,
  output logic        err_sticky,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [3:0] MUL_REMAIN = 4'd5;
  localparam logic [3:0] DIV_REMAIN = 4'd10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] remain;
  logic       is_arith;
  logic       protocol_err;

  // Ops 0-3 are mult/multu/div/divu; 4-7 only touch HI/LO.
  assign is_arith     = ~e_mdop[2];
  assign md_start     = ~reset & e_md_valid & is_arith & (state == IDLE);
  assign md_op        = e_md_valid ? e_mdop : 3'd0;
  assign stall_d      = ~reset & d_md_valid & (md_start | busy_shadow);
  // Nothing HI/LO-related may sit in E while an operation is running.
  assign protocol_err = e_md_valid & (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remain      <= 4'd0;
      busy_shadow <= 1'b0;
      err_sticky  <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state       <= e_mdop[1] ? RUN_DIV : RUN_MUL;
            remain      <= e_mdop[1] ? DIV_REMAIN : MUL_REMAIN;
            busy_shadow <= 1'b1;
          end
        end
        RUN_MUL, RUN_DIV: begin
          if (remain != 4'd0) begin
            remain <= remain - 4'd1;
          end else begin
            state       <= IDLE;
            busy_shadow <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          remain      <= 4'd0;
          busy_shadow <= 1'b0;
        end
      endcase

      if ((md_busy != busy_shadow) || protocol_err) begin
        err_sticky <= 1'b1;
      end

      if (stall_d && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Issue and stall controller for the multiply/divide unit in the five-stage pipeline. It sits beside the E stage. It generates the one-cycle start pulse and the op code for the multiply/divide unit, and tracks the unit's busy window with its own cycle counter. It also asserts the D-stage stall whenever an HI/LO-related instruction would collide with a running or just-issued operation. It keeps a sticky consistency flag (its own busy shadow vs. the unit's busy) and a saturating stall-cycle counter for performance checks.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- d_md_valid  in  1  instruction in D is any HI/LO instruction (op 0–7)
- e_md_valid  in  1  instruction in E is an HI/LO instruction
- e_mdop  in  3  op of E instruction: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
- md_busy  in  1  busy output of the multiply/divide unit
- md_start  out  1  start pulse to unit (combinational)
- md_op  out  3  op to unit: e_mdop when e_md_valid, else 3'd0
- stall_d  out  1  freeze PC/D, bubble into E (combinational)
- busy_shadow  out  1  controller's model of unit busy (registered)
- err_sticky  out  1  set on shadow/unit busy mismatch; cleared only by reset
- stall_cnt  out  16  saturating count of cycles with stall_d=1

## Operation
- States: IDLE, RUN_MUL, RUN_DIV. A 4-bit down-counter `remain` is associated with the states.
- md_start = e_md_valid & (e_mdop < 4) & (state == IDLE).
- On an edge with md_start=1:
  - mult/multu: go to RUN_MUL with remain=5.
  - div/divu: go to RUN_DIV with remain=10.
- In RUN_*:
  - remain≠0: decrement remain.
  - remain==0: return to IDLE.
- busy_shadow = (state ≠ IDLE).
- stall_d = d_md_valid & (md_start | busy_shadow). Every op in D stalls, including mthi/mtlo/mfhi/mflo.
- mthi/mtlo/mfhi/mflo in E: md_op is passed through and md_start stays 0. The stall rule guarantees these ops never reach E while the unit is busy.
- An E-stage op ≥4 with e_md_valid=1 while state≠IDLE is a protocol violation. It sets err_sticky. md_op is still driven.
- err_sticky is set on any rising edge where md_busy ≠ busy_shadow, or on a protocol violation.
- stall_cnt increments on each edge with stall_d=1 and saturates at 16'hFFFF.
- A start request while state≠IDLE cannot occur under correct stalling. If it does, it is ignored (md_start=0) and err_sticky is set.

## Timing
- Reset values: state=IDLE, remain=0, busy_shadow=0, err_sticky=0, stall_cnt=0. While reset is high: md_start=0, stall_d=0, md_op follows inputs.
- The unit resets synchronously. Reset must be held across at least one rising clk edge so both blocks leave reset idle. Reset mid-operation abandons the operation and leaves HI/LO as the unit defines.
- Mult issued in cycle T (md_start=1 in T):
  - busy_shadow=1 in T+1..T+6 (6 cycles); IDLE in T+7.
  - This matches md_busy exactly; the unit writes HI/LO at the end of T+6.
- Div issued in T: busy_shadow=1 in T+1..T+11 (11 cycles); IDLE in T+12.
- A HI/LO op in D during T..T+6 (mult) is stalled. It leaves D at the end of T+7 and reaches E in T+8.
- Back-to-back: a second mult in D during T is stalled. It issues at the earliest in T+8, with md_start=1 in T+8.
- Simultaneous reset assertion and start: reset wins, and no state change is recorded.
- stall_cnt saturation: at 16'hFFFF, further stall cycles leave it at 16'hFFFF.

## Test plan
- Reset mid-div: issue div at T=0, assert reset in T+4 → busy_shadow=0 and state IDLE immediately; stall_cnt=0; err_sticky=0 after release.
- mult in E at T with mflo in D → md_start=1 and stall_d=1 in T..T+6; stall_d=0 in T+7; busy_shadow matches md_busy every cycle; stall_cnt=7; err_sticky=0.
- div at T, mfhi behind it → stall_d=1 in T..T+11; busy_shadow drops at T+12; stall_cnt=12.
- mthi in E with no prior op → md_op=4, md_start=0, stall_d=0, busy_shadow=0.
- Fault injection: force md_busy=1 for one cycle while IDLE → err_sticky=1 and stays 1 until reset.
- Hold d_md_valid=1 with a permanent fake busy (mult every 7 cycles) for 70000 cycles → stall_cnt saturates at 16'hFFFF and does not wrap.
